// File: rtl/uart_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_scheduler
// Description : Shares one byte-wide UART transmitter between NREQ frame
//               sources. A round-robin arbiter picks a requester, latches its
//               fixed-length frame and feeds it MS byte first to the
//               transmitter via a tx_start / tx_done handshake. A per-byte
//               watchdog aborts the frame if the transmitter stalls.
// Ports       : clk_100MHz   - system clock (rising edge)
//               reset        - asynchronous active-high reset
//               req          - per-requester level request
//               frame_in     - NREQ packed frames, requester i at slice i
//               grant        - one-hot owner of the transmitter
//               done / err   - one-cycle completion / abort pulse on owner bit
//               busy         - high while a frame is owned
//               tx_data      - byte to transmit, stable until next tx_start
//               tx_start     - one-cycle transmit request
//               tx_done      - one-cycle byte-finished pulse from transmitter
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_scheduler #(
    parameter int NREQ        = 2,
    parameter int DBITS       = 8,
    parameter int FRAME_BYTES = 18,
    parameter int TIMEOUT     = 20000
) (
    input  logic                               clk_100MHz,
    input  logic                               reset,
    input  logic [NREQ-1:0]                    req,
    input  logic [NREQ*FRAME_BYTES*DBITS-1:0]  frame_in,
    output logic [NREQ-1:0]                    grant,
    output logic [NREQ-1:0]                    done,
    output logic [NREQ-1:0]                    err,
    output logic                               busy,
    output logic [DBITS-1:0]                   tx_data,
    output logic                               tx_start,
    input  logic                               tx_done
);

    localparam int c_FW = FRAME_BYTES * DBITS;
    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int c_WW = $clog2(TIMEOUT + 1);

    localparam logic [c_IW-1:0] c_LAST_REQ  = c_IW'(NREQ - 1);
    localparam logic [c_BW-1:0] c_LAST_BYTE = c_BW'(FRAME_BYTES - 1);
    localparam logic [c_WW-1:0] c_WDOG_MAX  = c_WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t            r_state;
    logic [c_FW-1:0]   r_frame;
    logic [c_BW-1:0]   r_byte_idx;
    logic [c_WW-1:0]   r_wdog;
    logic [c_IW-1:0]   r_rr_last;
    logic [c_IW-1:0]   r_owner;

    logic              w_found;
    logic [c_IW-1:0]   w_pick;
    logic [NREQ-1:0]   w_pick_oh;

    // Round-robin search: start just above the last owner and wrap, so the
    // previous owner is considered last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req[c_IW'((int'(r_rr_last) + k) % NREQ)]) begin
                w_found = 1'b1;
                w_pick  = c_IW'((int'(r_rr_last) + k) % NREQ);
            end
        end
    end

    assign w_pick_oh = NREQ'(1) << w_pick;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_frame    <= '0;
            r_byte_idx <= '0;
            r_wdog     <= '0;
            r_rr_last  <= c_LAST_REQ;
            r_owner    <= '0;
            grant      <= '0;
            done       <= '0;
            err        <= '0;
            busy       <= 1'b0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        grant      <= w_pick_oh;
                        busy       <= 1'b1;
                        r_owner    <= w_pick;
                        // Snapshot the frame so later frame_in changes are harmless.
                        r_frame    <= frame_in[int'(w_pick)*c_FW +: c_FW];
                        r_byte_idx <= '0;
                        r_state    <= S_SEND;
                    end
                end

                S_SEND: begin
                    tx_start <= 1'b1;
                    tx_data  <= r_frame[c_FW-1 -: DBITS];
                    r_wdog   <= '0;
                    r_state  <= S_WAIT;
                end

                S_WAIT: begin
                    tx_start <= 1'b0;
                    r_wdog   <= r_wdog + c_WW'(1);
                    // tx_done is tested first so a simultaneous timeout loses.
                    if (tx_done) begin
                        if (r_byte_idx == c_LAST_BYTE) begin
                            done    <= grant;
                            r_state <= S_DONE;
                        end else begin
                            r_frame    <= r_frame << DBITS;
                            r_byte_idx <= r_byte_idx + c_BW'(1);
                            r_state    <= S_SEND;
                        end
                    end else if (r_wdog == c_WDOG_MAX) begin
                        err     <= grant;
                        r_state <= S_ABORT;
                    end
                end

                S_DONE, S_ABORT: begin
                    done      <= '0;
                    err       <= '0;
                    grant     <= '0;
                    busy      <= 1'b0;
                    r_rr_last <= r_owner;
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_scheduler
// Description : Self-checking bench for uart_frame_scheduler. Instance A uses
//               18-byte frames with a slow transmitter model; instance B uses
//               2-byte frames, TIMEOUT=50 and a fast transmitter model.
//               Expected bytes are queued when requests are raised and popped
//               as tx_start pulses appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_scheduler;

    localparam int c_LAT_A = 100;
    localparam int c_LAT_B = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A signals
    logic [1:0]   req_a = '0;
    logic [287:0] frame_a = '0;
    logic [1:0]   grant_a, done_a, err_a;
    logic         busy_a, txs_a, txdone_a;
    logic [7:0]   txd_a;

    // Instance B signals
    logic [1:0]   req_b = '0;
    logic [31:0]  frame_b = '0;
    logic [1:0]   grant_b, done_b, err_b;
    logic         busy_b, txs_b, txdone_b;
    logic [7:0]   txd_b;

    uart_frame_scheduler #(
        .NREQ(2), .DBITS(8), .FRAME_BYTES(18), .TIMEOUT(20000)
    ) dut_a (
        .clk_100MHz(clk), .reset(rst), .req(req_a), .frame_in(frame_a),
        .grant(grant_a), .done(done_a), .err(err_a), .busy(busy_a),
        .tx_data(txd_a), .tx_start(txs_a), .tx_done(txdone_a)
    );

    uart_frame_scheduler #(
        .NREQ(2), .DBITS(8), .FRAME_BYTES(2), .TIMEOUT(50)
    ) dut_b (
        .clk_100MHz(clk), .reset(rst), .req(req_b), .frame_in(frame_b),
        .grant(grant_b), .done(done_b), .err(err_b), .busy(busy_b),
        .tx_data(txd_b), .tx_start(txs_b), .tx_done(txdone_b)
    );

    // Transmitter models: answer each tx_start with a tx_done pulse.
    bit   en_a = 1'b1;
    bit   en_b = 1'b1;
    int   cnt_a, cnt_b;
    logic mdone_a, mdone_b;
    logic inj_b = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a   <= 0;
            cnt_b   <= 0;
            mdone_a <= 1'b0;
            mdone_b <= 1'b0;
        end else begin
            mdone_a <= (cnt_a == 1);
            mdone_b <= (cnt_b == 1);
            if (txs_a && en_a)   cnt_a <= c_LAT_A;
            else if (cnt_a > 0)  cnt_a <= cnt_a - 1;
            if (txs_b && en_b)   cnt_b <= c_LAT_B;
            else if (cnt_b > 0)  cnt_b <= cnt_b - 1;
        end
    end

    assign txdone_a = mdone_a;
    assign txdone_b = mdone_b | inj_b;

    // Pulse counters sampled on the rising edge (previous-cycle values).
    int nts_a = 0, nts_b = 0, nev_a = 0;
    always @(posedge clk) begin
        if (txs_a) nts_a++;
        if (txs_b) nts_b++;
        if ((done_a | err_a) != 2'b00) nev_a++;
    end

    // Generic view of the instance under test.
    bit         sel_b = 1'b0;
    wire        m_txs = sel_b ? txs_b : txs_a;
    wire [1:0]  m_evt = sel_b ? (done_b | err_b) : (done_a | err_a);

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic wait_txs(input int budget, output bit ok, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_txs && n < budget);
        ok = m_txs;
    endtask

    task automatic wait_evt(input int budget, output bit ok, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_evt == 2'b00 && n < budget);
        ok = (m_evt != 2'b00);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant_a, done_a, err_a, busy_a, txd_a, txs_a} !== 16'h0) begin
            errors++;
            $display("FAIL reset_a: got %h want 0", {grant_a, done_a, err_a, busy_a, txd_a, txs_a});
        end
        checks++;
        if ({grant_b, done_b, err_b, busy_b, txd_b, txs_b} !== 16'h0) begin
            errors++;
            $display("FAIL reset_b: got %h want 0", {grant_b, done_b, err_b, busy_b, txd_b, txs_b});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (grant_a !== 2'b00 || busy_a !== 1'b0 || txs_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: grant=%b busy=%b txs=%b want 00 0 0", grant_a, busy_a, txs_a);
        end
    endtask

    task automatic test_single_frame();
        logic [143:0] f;
        logic [7:0]   e;
        bit           ok;
        int           n;
        int           n0;
        sel_b = 1'b0;
        f = "{hi_i'm_your_army}";
        frame_a[143:0] = f;
        for (int i = 0; i < 18; i++) exp_q.push_back(f[143-8*i -: 8]);
        n0 = nts_a;
        req_a = 2'b01;
        wait_txs(10, ok, n);
        checks++;
        if (!ok || n != 2) begin
            errors++;
            $display("FAIL s1_latency: seen=%0b after %0d edges want 2", ok, n);
        end
        checks++;
        if (grant_a !== 2'b01 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL s1_grant: grant=%b busy=%b want 01 1", grant_a, busy_a);
        end
        e = exp_q.pop_front();
        checks++;
        if (txd_a !== e) begin
            errors++;
            $display("FAIL s1_byte0: got %h want %h", txd_a, e);
        end
        for (int i = 1; i < 18; i++) begin
            wait_txs(300, ok, n);
            e = exp_q.pop_front();
            checks++;
            if (!ok || txd_a !== e) begin
                errors++;
                $display("FAIL s1_byte%0d: got %h (seen=%0b) want %h", i, txd_a, ok, e);
            end
        end
        wait_evt(300, ok, n);
        checks++;
        if (!ok || done_a !== 2'b01 || err_a !== 2'b00) begin
            errors++;
            $display("FAIL s1_done: done=%b err=%b want 01 00", done_a, err_a);
        end
        req_a = 2'b00;
        @(negedge clk);
        checks++;
        if (done_a !== 2'b00 || busy_a !== 1'b0 || grant_a !== 2'b00) begin
            errors++;
            $display("FAIL s1_release: done=%b busy=%b grant=%b want 00 0 00", done_a, busy_a, grant_a);
        end
        checks++;
        if (nts_a - n0 != 18) begin
            errors++;
            $display("FAIL s1_pulses: got %0d tx_start want 18", nts_a - n0);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        logic [7:0] e;
        bit         ok;
        int         n;
        sel_b = 1'b1;
        en_b = 1'b1;
        frame_b = 32'h4344_4142;
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(8'h41 + 8'(2 * (f % 2)));
            exp_q.push_back(8'h42 + 8'(2 * (f % 2)));
        end
        req_b = 2'b11;
        for (int f = 0; f < 3; f++) begin
            g = (f % 2 == 0) ? 2'b01 : 2'b10;
            for (int b = 0; b < 2; b++) begin
                wait_txs(50, ok, n);
                e = exp_q.pop_front();
                checks++;
                if (!ok || txd_b !== e || grant_b !== g) begin
                    errors++;
                    $display("FAIL rr_f%0d_b%0d: byte %h grant %b (seen=%0b) want %h %b", f, b, txd_b, grant_b, ok, e, g);
                end
            end
            wait_evt(50, ok, n);
            if (f == 2) req_b = 2'b00;
            checks++;
            if (!ok || done_b !== g || err_b !== 2'b00) begin
                errors++;
                $display("FAIL rr_done%0d: done=%b err=%b want %b 00", f, done_b, err_b, g);
            end
        end
        @(negedge clk);
        checks++;
        if (grant_b !== 2'b00 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL rr_release: grant=%b busy=%b want 00 0", grant_b, busy_b);
        end
    endtask

    task automatic test_req_drop();
        logic [143:0] f1;
        logic [7:0]   e;
        bit           ok;
        int           n;
        sel_b = 1'b0;
        for (int i = 0; i < 18; i++) f1[143-8*i -: 8] = 8'hA0 + 8'(i);
        frame_a[287:144] = f1;
        for (int i = 0; i < 18; i++) exp_q.push_back(f1[143-8*i -: 8]);
        req_a = 2'b10;
        for (int i = 0; i < 18; i++) begin
            wait_txs(300, ok, n);
            e = exp_q.pop_front();
            checks++;
            if (!ok || txd_a !== e || grant_a !== 2'b10) begin
                errors++;
                $display("FAIL drop_byte%0d: byte %h grant %b (seen=%0b) want %h 10", i, txd_a, grant_a, ok, e);
            end
            if (i == 3) begin
                req_a = 2'b00;
                frame_a[287:144] = ~f1;
            end
        end
        wait_evt(300, ok, n);
        checks++;
        if (!ok || done_a !== 2'b10 || err_a !== 2'b00) begin
            errors++;
            $display("FAIL drop_done: done=%b err=%b want 10 00", done_a, err_a);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [7:0] e;
        bit         ok;
        int         n;
        sel_b = 1'b1;
        en_b = 1'b0;
        exp_q.push_back(8'h41);
        req_b = 2'b01;
        wait_txs(10, ok, n);
        e = exp_q.pop_front();
        checks++;
        if (!ok || txd_b !== e || grant_b !== 2'b01) begin
            errors++;
            $display("FAIL to_start: byte %h grant %b (seen=%0b) want %h 01", txd_b, grant_b, ok, e);
        end
        wait_evt(100, ok, n);
        checks++;
        if (!ok || n != 50 || err_b !== 2'b01 || done_b !== 2'b00) begin
            errors++;
            $display("FAIL to_err: err=%b done=%b after %0d cycles want 01 00 after 50", err_b, done_b, n);
        end
        req_b = 2'b00;
        @(negedge clk);
        checks++;
        if (err_b !== 2'b00 || grant_b !== 2'b00 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL to_release: err=%b grant=%b busy=%b want 00 00 0", err_b, grant_b, busy_b);
        end
        en_b = 1'b1;
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h44);
        req_b = 2'b10;
        for (int b = 0; b < 2; b++) begin
            wait_txs(50, ok, n);
            e = exp_q.pop_front();
            checks++;
            if (!ok || txd_b !== e || grant_b !== 2'b10) begin
                errors++;
                $display("FAIL to_next_b%0d: byte %h grant %b (seen=%0b) want %h 10", b, txd_b, grant_b, ok, e);
            end
        end
        wait_evt(50, ok, n);
        req_b = 2'b00;
        checks++;
        if (!ok || done_b !== 2'b10 || err_b !== 2'b00) begin
            errors++;
            $display("FAIL to_next_done: done=%b err=%b want 10 00", done_b, err_b);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic [143:0] f;
        logic [7:0]   e;
        bit           ok;
        int           n;
        int           ev0;
        sel_b = 1'b0;
        f = "{hi_i'm_your_army}";
        frame_a[143:0] = f;
        frame_a[287:144] = '0;
        for (int i = 0; i < 18; i++) exp_q.push_back(f[143-8*i -: 8]);
        ev0 = nev_a;
        req_a = 2'b01;
        for (int i = 0; i < 6; i++) begin
            wait_txs(300, ok, n);
            e = exp_q.pop_front();
            checks++;
            if (!ok || txd_a !== e) begin
                errors++;
                $display("FAIL rm_byte%0d: got %h (seen=%0b) want %h", i, txd_a, ok, e);
            end
        end
        exp_q.delete();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({grant_a, done_a, err_a, busy_a, txd_a, txs_a} !== 16'h0) begin
            errors++;
            $display("FAIL rm_async: got %h want 0", {grant_a, done_a, err_a, busy_a, txd_a, txs_a});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req_a = 2'b11;
        wait_txs(10, ok, n);
        checks++;
        if (!ok || n != 2 || grant_a !== 2'b01 || txd_a !== 8'h7b) begin
            errors++;
            $display("FAIL rm_regrant: grant=%b byte=%h edges=%0d want 01 7b 2", grant_a, txd_a, n);
        end
        checks++;
        if (nev_a != ev0) begin
            errors++;
            $display("FAIL rm_no_event: got %0d done/err cycles want 0", nev_a - ev0);
        end
        rst = 1'b1;
        req_a = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_spurious_tx_done();
        logic [7:0] e;
        bit         ok;
        int         n;
        int         n0;
        sel_b = 1'b1;
        en_b = 1'b1;
        frame_b = 32'h4344_4142;
        n0 = nts_b;
        inj_b = 1'b1;
        @(negedge clk);
        inj_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (nts_b != n0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL sp_idle: tx_start count %0d busy %b want 0 0", nts_b - n0, busy_b);
        end
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        req_b = 2'b01;
        @(negedge clk);
        inj_b = 1'b1;
        @(negedge clk);
        inj_b = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (txs_b !== 1'b1 || txd_b !== e || grant_b !== 2'b01) begin
            errors++;
            $display("FAIL sp_first: txs=%b byte=%h grant=%b want 1 %h 01", txs_b, txd_b, grant_b, e);
        end
        wait_txs(50, ok, n);
        e = exp_q.pop_front();
        checks++;
        if (!ok || txd_b !== e) begin
            errors++;
            $display("FAIL sp_second: byte %h (seen=%0b) want %h", txd_b, ok, e);
        end
        wait_evt(50, ok, n);
        req_b = 2'b00;
        checks++;
        if (!ok || done_b !== 2'b01 || err_b !== 2'b00) begin
            errors++;
            $display("FAIL sp_done: done=%b err=%b want 01 00", done_b, err_b);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (nts_b - n0 != 2) begin
            errors++;
            $display("FAIL sp_pulses: got %0d tx_start want 2", nts_b - n0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_req_drop();
        test_timeout();
        test_reset_midframe();
        test_spurious_tx_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
